// File: rtl/plru_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | plru_pkg : shared types and tree-PLRU helpers for the 8-way LLC engine.   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package plru_pkg;

   localparam int PLRU_SIZE = 7;
   localparam int WAY_SIZE  = 3;
   localparam int NUM_WAYS  = 8;

   typedef enum logic [1:0] {
      OP_TOUCH = 2'b00,
      OP_ALLOC = 2'b01,
      OP_PEEK  = 2'b10,
      OP_RSVD  = 2'b11
   } plru_op_e;

   typedef logic [PLRU_SIZE-1:0] plru_t;
   typedef logic [WAY_SIZE-1:0]  way_t;

   // Bit 0 is the root; a node bit records which side was touched last.
   function automatic plru_t plru_update(input plru_t p, input way_t w);
      plru_t res;
      res = p;
      case (w)
         3'd0: begin res[0] = 1'b0; res[1] = 1'b0; res[3] = 1'b0; end
         3'd1: begin res[0] = 1'b0; res[1] = 1'b0; res[3] = 1'b1; end
         3'd2: begin res[0] = 1'b0; res[1] = 1'b1; res[4] = 1'b0; end
         3'd3: begin res[0] = 1'b0; res[1] = 1'b1; res[4] = 1'b1; end
         3'd4: begin res[0] = 1'b1; res[2] = 1'b0; res[5] = 1'b0; end
         3'd5: begin res[0] = 1'b1; res[2] = 1'b0; res[5] = 1'b1; end
         3'd6: begin res[0] = 1'b1; res[2] = 1'b1; res[6] = 1'b0; end
         default: begin res[0] = 1'b1; res[2] = 1'b1; res[6] = 1'b1; end
      endcase
      return res;
   endfunction

   function automatic way_t plru_walk(input plru_t p);
      way_t w;
      if (p[0]) begin
         w = p[1] ? (p[3] ? 3'd0 : 3'd1) : (p[4] ? 3'd2 : 3'd3);
      end else begin
         w = p[2] ? (p[5] ? 3'd4 : 3'd5) : (p[6] ? 3'd6 : 3'd7);
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/plru_victim_engine_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | plru_victim_engine_if : request/response bus between LLC controller and   |
// | the PLRU engine.                                              Rev 1.0     |
// +---------------------------------------------------------------------------+
interface plru_victim_engine_if #(
   parameter int SET_BITS = 6
);
   import plru_pkg::*;

   logic                req_valid;
   logic                req_ready;
   logic [1:0]          req_op;
   logic [SET_BITS-1:0] req_set;
   way_t                req_way;
   logic [7:0]          req_valid_mask;

   logic                rsp_valid;
   logic                rsp_ready;
   way_t                rsp_way;
   logic                rsp_from_invalid;
   plru_t               rsp_plru;

   modport master (
      output req_valid, req_op, req_set, req_way, req_valid_mask, rsp_ready,
      input  req_ready, rsp_valid, rsp_way, rsp_from_invalid, rsp_plru
   );

   modport slave (
      input  req_valid, req_op, req_set, req_way, req_valid_mask, rsp_ready,
      output req_ready, rsp_valid, rsp_way, rsp_from_invalid, rsp_plru
   );

endinterface
`default_nettype wire

// File: rtl/plru_victim_select.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | plru_victim_select : combinational victim pick from a PLRU word; with     |
// | PLRU_INVALID_FIRST_EN an invalid way wins over the tree.      Rev 1.0     |
// +---------------------------------------------------------------------------+
module plru_victim_select
   import plru_pkg::*;
(
   input  plru_t      i_plru,
   input  logic [7:0] i_valid_mask,
   output way_t       o_way,
   output logic       o_from_invalid
);

`ifdef PLRU_INVALID_FIRST_EN
   // Descending scan so the lowest invalid index is the one that sticks.
   always_comb begin
      o_way          = plru_walk(i_plru);
      o_from_invalid = 1'b0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!i_valid_mask[i]) begin
            o_way          = way_t'(i);
            o_from_invalid = 1'b1;
         end
      end
   end
`else
   logic w_unused_mask;

   assign w_unused_mask  = ^i_valid_mask;
   assign o_way          = plru_walk(i_plru);
   assign o_from_invalid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/plru_victim_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | plru_victim_engine : per-set tree-PLRU store serving TOUCH/ALLOC/PEEK.    |
// | Optional macro PLRU_INVALID_FIRST_EN.                         Rev 1.0     |
// +---------------------------------------------------------------------------+
module plru_victim_engine
   import plru_pkg::*;
#(
   parameter int NUM_SETS = 64,
   parameter int SET_BITS = $clog2(NUM_SETS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   plru_victim_engine_if.slave  bus,
   output logic                 init_done
);

   localparam logic [0:0]          c_st_init  = 1'b0;
   localparam logic [0:0]          c_st_run   = 1'b1;
   localparam logic [SET_BITS-1:0] c_last_set = SET_BITS'(NUM_SETS - 1);

   logic [0:0]          r_state;
   logic [SET_BITS-1:0] r_cnt;
   logic                r_init_done;
   plru_t               r_plru [NUM_SETS];

   logic                r_rsp_valid;
   way_t                r_rsp_way;
   logic                r_rsp_from_invalid;
   plru_t               r_rsp_plru;

   plru_op_e            w_op;
   plru_t               w_cur;
   plru_t               w_next;
   way_t                w_victim;
   way_t                w_rsp_way;
   logic                w_from_invalid;
   logic                w_rsp_fi;
   logic                w_is_touch;
   logic                w_writes;
   logic                w_req_ready;
   logic                w_accept;
   logic                w_wr_en;
   logic [SET_BITS-1:0] w_wr_set;
   plru_t               w_wr_data;

   assign w_op  = plru_op_e'(bus.req_op);
   assign w_cur = r_plru[bus.req_set];

   plru_victim_select u_sel (
      .i_plru         (w_cur),
      .i_valid_mask   (bus.req_valid_mask),
      .o_way          (w_victim),
      .o_from_invalid (w_from_invalid)
   );

   always_comb begin
      w_is_touch = 1'b0;
      w_writes   = 1'b0;
      case (w_op)
         OP_TOUCH: begin
            w_is_touch = 1'b1;
            w_writes   = 1'b1;
         end
         OP_ALLOC: w_writes = 1'b1;
         default:  w_writes = 1'b0;
      endcase
   end

   assign w_rsp_way   = w_is_touch ? bus.req_way : w_victim;
   assign w_rsp_fi    = w_is_touch ? 1'b0 : w_from_invalid;
   assign w_next      = w_writes ? plru_update(w_cur, w_rsp_way) : w_cur;
   assign w_req_ready = (r_state == c_st_run) && (!r_rsp_valid || bus.rsp_ready);
   assign w_accept    = bus.req_valid && w_req_ready;

   // Single write port shared by the init sweep and run-time write-back.
   assign w_wr_en   = (r_state == c_st_init) || (w_accept && w_writes);
   assign w_wr_set  = (r_state == c_st_init) ? r_cnt : bus.req_set;
   assign w_wr_data = (r_state == c_st_init) ? '0 : w_next;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_plru[w_wr_set] <= w_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_st_init;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
      end else if (r_state == c_st_init) begin
         r_cnt <= r_cnt + SET_BITS'(1);
         if (r_cnt == c_last_set) begin
            r_state     <= c_st_run;
            r_init_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid        <= 1'b0;
         r_rsp_way          <= '0;
         r_rsp_from_invalid <= 1'b0;
         r_rsp_plru         <= '0;
      end else if (w_accept) begin
         r_rsp_valid        <= 1'b1;
         r_rsp_way          <= w_rsp_way;
         r_rsp_from_invalid <= w_rsp_fi;
         r_rsp_plru         <= w_next;
      end else if (bus.rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign bus.req_ready        = w_req_ready;
   assign bus.rsp_valid        = r_rsp_valid;
   assign bus.rsp_way          = r_rsp_way;
   assign bus.rsp_from_invalid = r_rsp_from_invalid;
   assign bus.rsp_plru         = r_rsp_plru;
   assign init_done            = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_plru_victim_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_plru_victim_engine : randomized self-checking bench with tree model.   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_plru_victim_engine;

   localparam int NSETS = 64;

   logic clk;
   logic rst_n;
   logic init_done;

   int n_checks = 0;
   int n_fail   = 0;

   bit [6:0] m_tree [NSETS];
   int       last_way;
   int       last_fi;
   int       last_plru;

   plru_victim_engine_if #(.SET_BITS(6)) bus ();

   plru_victim_engine #(.NUM_SETS(NSETS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .init_done (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Tree as a binary heap: node n has children 2n+1 (left) and 2n+2 (right).
   function automatic bit [6:0] m_touch(input bit [6:0] t, input int w);
      bit [6:0] r;
      int       n;
      r = t;
      n = 0;
      for (int l = 2; l >= 0; l--) begin
         int b;
         b    = (w >> l) & 1;
         r[n] = b[0];
         n    = 2 * n + 1 + b;
      end
      return r;
   endfunction

   function automatic int m_victim(input bit [6:0] t);
      int n;
      int w;
      n = 0;
      w = 0;
      for (int l = 0; l < 3; l++) begin
         int d;
         d = t[n] ? 0 : 1;
         w = 2 * w + d;
         n = 2 * n + 1 + d;
      end
      return w;
   endfunction

   function automatic void m_apply(input int op, input int set, input int way, input bit [7:0] mask,
                                   output int ew, output bit efi, output bit [6:0] ep);
      bit [6:0] cur;
      bit       fi_en;
`ifdef PLRU_INVALID_FIRST_EN
      fi_en = 1'b1;
`else
      fi_en = 1'b0;
`endif
      cur = m_tree[set];
      ew  = m_victim(cur);
      efi = 1'b0;
      if (fi_en && op != 0 && mask != 8'hFF) begin
         for (int i = 7; i >= 0; i--) begin
            if (!mask[i]) ew = i;
         end
         efi = 1'b1;
      end
      if (op == 0) begin
         ew  = way;
         efi = 1'b0;
      end
      ep = (op == 0 || op == 1) ? m_touch(cur, ew) : cur;
      m_tree[set] = ep;
   endfunction

   // Called at a negedge; returns at the negedge where the response is visible.
   task automatic issue(input int op, input int set, input int way, input bit [7:0] mask);
      int       guard;
      int       ew;
      bit       efi;
      bit [6:0] ep;
      bus.req_valid      = 1'b1;
      bus.req_op         = 2'(op);
      bus.req_set        = 6'(set);
      bus.req_way        = 3'(way);
      bus.req_valid_mask = mask;
      guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         chk_val("accept_timeout", 32'd0, 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      m_apply(op, set, way, mask, ew, efi, ep);
      @(negedge clk);
      bus.req_valid = 1'b0;
      last_way  = int'(bus.rsp_way);
      last_fi   = int'(bus.rsp_from_invalid);
      last_plru = int'(bus.rsp_plru);
      chk_val("rsp_valid", bus.rsp_valid, 32'd1);
      chk_val("rsp_way", bus.rsp_way, ew);
      chk_val("rsp_from_invalid", bus.rsp_from_invalid, efi);
      chk_val("rsp_plru", bus.rsp_plru, ep);
   endtask

   task automatic wait_init(output int cycles, output int rdy_bad);
      cycles  = 0;
      rdy_bad = 0;
      while (cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         if (init_done === 1'b1) break;
         if (bus.req_ready !== 1'b0) rdy_bad++;
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NSETS; i++) m_tree[i] = 7'd0;
   endtask

   initial begin
      int       cyc;
      int       bad;
      int       h_way;
      int       h_fi;
      int       h_plru;
      int       ew;
      bit       efi;
      bit [6:0] ep;

      rst_n              = 1'b0;
      bus.req_valid      = 1'b1;
      bus.req_op         = 2'b10;
      bus.req_set        = 6'd0;
      bus.req_way        = 3'd0;
      bus.req_valid_mask = 8'hFF;
      bus.rsp_ready      = 1'b1;
      clear_model();

      repeat (3) @(negedge clk);
      chk_val("rst_rsp_valid", bus.rsp_valid, 32'd0);
      chk_val("rst_rsp_way", bus.rsp_way, 32'd0);
      chk_val("rst_rsp_fi", bus.rsp_from_invalid, 32'd0);
      chk_val("rst_rsp_plru", bus.rsp_plru, 32'd0);
      chk_val("rst_init_done", init_done, 32'd0);
      chk_val("rst_req_ready", bus.req_ready, 32'd0);

      rst_n = 1'b1;
      wait_init(cyc, bad);
      chk_val("init_cycles", cyc, 32'd64);
      chk_val("init_req_ready_low", bad, 32'd0);
      @(negedge clk);
      chk_val("no_accept_in_init", bus.rsp_valid, 32'd0);

      // Directed sequence on set 5 from the fresh tree.
      issue(1, 5, 0, 8'hFF);
      chk_val("tp_alloc1_way", last_way, 32'd7);
      chk_val("tp_alloc1_plru", last_plru, 32'h45);
      issue(1, 5, 0, 8'hFF);
      chk_val("tp_alloc2_way", last_way, 32'd3);
      chk_val("tp_alloc2_plru", last_plru, 32'h56);
      issue(0, 5, 0, 8'hFF);
      chk_val("tp_touch_plru", last_plru, 32'h54);
      issue(2, 5, 0, 8'hFF);
      chk_val("tp_peek_way", last_way, 32'd5);
      chk_val("tp_peek_plru", last_plru, 32'h54);
      issue(2, 5, 0, 8'hFF);
      chk_val("tp_peek2_way", last_way, 32'd5);
      chk_val("tp_peek2_plru", last_plru, 32'h54);
      issue(1, 9, 0, 8'b1111_1011);
`ifdef PLRU_INVALID_FIRST_EN
      chk_val("tp_inv_way", last_way, 32'd2);
      chk_val("tp_inv_fi", last_fi, 32'd1);
      chk_val("tp_inv_plru", last_plru, 32'h02);
`else
      chk_val("tp_inv_way", last_way, 32'd7);
      chk_val("tp_inv_fi", last_fi, 32'd0);
`endif

      // Response back-pressure with a second request waiting.
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      issue(1, 12, 0, 8'hFF);
      h_way  = int'(bus.rsp_way);
      h_fi   = int'(bus.rsp_from_invalid);
      h_plru = int'(bus.rsp_plru);
      bus.req_valid      = 1'b1;
      bus.req_op         = 2'b00;
      bus.req_set        = 6'd12;
      bus.req_way        = 3'd6;
      bus.req_valid_mask = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_val("hold_valid", bus.rsp_valid, 32'd1);
         chk_val("hold_way", bus.rsp_way, h_way);
         chk_val("hold_fi", bus.rsp_from_invalid, h_fi);
         chk_val("hold_plru", bus.rsp_plru, h_plru);
         chk_val("hold_req_ready", bus.req_ready, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      m_apply(0, 12, 6, 8'hFF, ew, efi, ep);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk_val("bp_second_valid", bus.rsp_valid, 32'd1);
      chk_val("bp_second_way", bus.rsp_way, 32'd6);
      chk_val("bp_second_plru", bus.rsp_plru, ep);

      // Randomized traffic, concentrated on a few sets to exercise coherence.
      for (int it = 0; it < 300; it++) begin
         int       op;
         int       set;
         int       way;
         bit [7:0] mask;
         op   = $urandom_range(0, 3);
         set  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NSETS - 1) : $urandom_range(0, 7);
         way  = $urandom_range(0, 7);
         mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         issue(op, set, way, mask);
      end

      // Reset pulse in the middle of initialisation.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_val("rst2_init_done", init_done, 32'd0);
      chk_val("rst2_rsp_valid", bus.rsp_valid, 32'd0);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b10;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_val("mid_init_done_low", init_done, 32'd0);
      rst_n = 1'b1;
      clear_model();
      wait_init(cyc, bad);
      chk_val("reinit_cycles", cyc, 32'd64);
      chk_val("reinit_req_ready_low", bad, 32'd0);
      @(negedge clk);
      chk_val("reinit_no_accept", bus.rsp_valid, 32'd0);

      for (int s = 0; s < NSETS; s++) begin
         issue(2, s, 0, 8'hFF);
         chk_val("reinit_peek_plru", last_plru, 32'd0);
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
